// File: rtl/text_scheduler_if.sv
// text_scheduler_if: game-event requests in, overlay message select/enable out
interface text_scheduler_if;
  logic       vsync_in;
  logic       req_level;
  logic [1:0] level_in;
  logic       req_pause;
  logic       req_gameover;
  logic       text_en;
  logic [2:0] msg_id;
  logic       busy;
  logic       done;
  modport master (
    output vsync_in, req_level, level_in, req_pause, req_gameover,
    input  text_en, msg_id, busy, done
  );
  modport slave (
    input  vsync_in, req_level, level_in, req_pause, req_gameover,
    output text_en, msg_id, busy, done
  );
endinterface

// File: rtl/text_scheduler.sv
// text_scheduler: prioritises level/pause/game-over events into overlay message index and enable.
// Define TEXT_SCHED_BLINK_EN to blink the PAUSED message every BLINK_FRAMES frames.
module text_scheduler #(
  parameter int SHOW_FRAMES  = 120,
  parameter int BLINK_FRAMES = 16
) (
  input logic pclk,
  input logic rst,
  text_scheduler_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHOW  = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;
  logic [1:0]  state;
  logic [1:0]  lvl;
  logic [1:0]  pend_lvl;
  logic [11:0] frame_cnt;
  logic        pend_v;
  logic        susp;
  logic        vsync_q;
  logic        exp_q;
  logic        tick;
  logic        last;
  logic        pause_en;
  assign tick = bus.vsync_in & ~vsync_q;
  assign last = frame_cnt == 12'(SHOW_FRAMES - 1);
`ifdef TEXT_SCHED_BLINK_EN
  logic [7:0] blink_cnt;
  logic       blink_on;
  // held at its entry value outside PAUSE, so every PAUSE entry starts visible with a fresh count
  always_ff @(posedge pclk) begin
    if (rst || state != PAUSE) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (tick) begin
      blink_cnt <= blink_cnt == 8'(BLINK_FRAMES - 1) ? 8'd0 : blink_cnt + 8'd1;
      blink_on  <= blink_cnt == 8'(BLINK_FRAMES - 1) ? ~blink_on : blink_on;
    end
  end
  assign pause_en = blink_on;
`else
  assign pause_en = 1'b1;
`endif
  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= IDLE;
      lvl         <= '0;
      pend_lvl    <= '0;
      frame_cnt   <= '0;
      pend_v      <= 1'b0;
      susp        <= 1'b0;
      vsync_q     <= 1'b0;
      exp_q       <= 1'b0;
      bus.text_en <= 1'b0;
      bus.msg_id  <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      vsync_q <= bus.vsync_in;
      exp_q   <= 1'b0;
      case (state)
        IDLE, SHOW: begin
          if (bus.req_gameover) state <= OVER;
          else if (bus.req_pause) begin
            state <= PAUSE;
            susp  <= state == SHOW;
          end else if (bus.req_level) begin
            state     <= SHOW;
            lvl       <= bus.level_in;
            frame_cnt <= '0;
          end else if (state == SHOW && tick) begin
            state     <= last ? IDLE : SHOW;
            exp_q     <= last;
            frame_cnt <= last ? frame_cnt : frame_cnt + 12'd1;
          end
        end
        PAUSE: begin
          if (bus.req_gameover) state <= OVER;
          else if (bus.req_pause) begin
            pend_v   <= pend_v | bus.req_level;
            pend_lvl <= bus.req_level ? bus.level_in : pend_lvl;
          end else if (bus.req_level || pend_v) begin
            state     <= SHOW;
            lvl       <= bus.req_level ? bus.level_in : pend_lvl;
            frame_cnt <= '0;
            pend_v    <= 1'b0;
            susp      <= 1'b0;
          end else begin
            state <= susp ? SHOW : IDLE;
            susp  <= 1'b0;
          end
        end
        default: state <= OVER;
      endcase
      bus.text_en <= state == SHOW || state == OVER || (state == PAUSE && pause_en);
      bus.msg_id  <= state == SHOW ? {1'b0, lvl} + 3'd1 :
                     state == PAUSE ? 3'd5 : state == OVER ? 3'd6 : 3'd0;
      bus.busy    <= state != IDLE;
      bus.done    <= exp_q;
    end
  end
endmodule

// File: tb/tb_text_scheduler.sv
// tb_text_scheduler: directed scoreboard bench for text_scheduler (SHOW_FRAMES=3, BLINK_FRAMES=2).
module tb_text_scheduler;
  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [5:0] sb[$];
  text_scheduler_if bus ();
  text_scheduler #(.SHOW_FRAMES(3), .BLINK_FRAMES(2)) dut (.pclk(pclk), .rst(rst), .bus(bus));
  always #5 pclk = ~pclk;
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask
  task automatic expect_out(input logic [2:0] m, input logic e, input logic b, input logic d);
    sb.push_back({m, e, b, d});
  endtask
  task automatic chk(input string tag);
    logic [5:0] obs;
    logic [5:0] want;
    obs = {bus.msg_id, bus.text_en, bus.busy, bus.done};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h but no expected entry queued", tag, obs);
    end else begin
      want = sb.pop_front();
      assert (obs === want) else begin
        errors++;
        $error("FAIL %s: {msg,en,busy,done} observed %b_%b%b%b expected %b_%b%b%b",
               tag, obs[5:3], obs[2], obs[1], obs[0], want[5:3], want[2], want[1], want[0]);
      end
    end
  endtask
  task automatic pulse_level(input logic [1:0] l);
    bus.level_in  = l;
    bus.req_level = 1'b1;
    cyc(1);
    bus.req_level = 1'b0;
  endtask
  task automatic frame();
    bus.vsync_in = 1'b1;
    cyc(2);
    bus.vsync_in = 1'b0;
    cyc(2);
  endtask
  task automatic expire(input logic [2:0] m, input string tag);
    bus.vsync_in = 1'b1;
    expect_out(3'd0, 1'b0, 1'b0, 1'b1);
    cyc(2);
    chk({tag, "_done"});
    expect_out(3'd0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    chk({tag, "_done_drop"});
    bus.vsync_in = 1'b0;
    cyc(2);
  endtask
  function automatic logic blink_exp(input int k);
`ifdef TEXT_SCHED_BLINK_EN
    return ((k / 2) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction
  initial begin
    bus.vsync_in = 0; bus.req_level = 0; bus.level_in = 0; bus.req_pause = 0; bus.req_gameover = 0;
    cyc(2);
    rst = 1'b0;
    expect_out(3'd0, 0, 0, 0);
    cyc(1);
    chk("reset");
    pulse_level(2'd2);
    expect_out(3'd3, 1, 1, 0);
    cyc(1);
    chk("show_l2");
    frame();
    expect_out(3'd3, 1, 1, 0);
    chk("tick1");
    frame();
    expect_out(3'd3, 1, 1, 0);
    chk("tick2");
    expire(3'd3, "expire");
    pulse_level(2'd2);
    cyc(1);
    frame();
    bus.req_pause = 1'b1;
    cyc(2);
    expect_out(3'd5, 1, 1, 0);
    chk("pause_entry");
    for (int k = 1; k <= 7; k++) begin
      frame();
      expect_out(3'd5, blink_exp(k), 1, 0);
      chk($sformatf("pause_frame%0d", k));
    end
    bus.req_pause = 1'b0;
    cyc(2);
    expect_out(3'd3, 1, 1, 0);
    chk("resume");
    frame();
    expect_out(3'd3, 1, 1, 0);
    chk("resume_tick");
    expire(3'd3, "resume_expire");
    pulse_level(2'd1);
    cyc(1);
    bus.req_pause = 1'b1;
    cyc(2);
    pulse_level(2'd0);
    cyc(1);
    pulse_level(2'd3);
    cyc(1);
    expect_out(3'd5, 1, 1, 0);
    chk("pause_pending");
    bus.req_pause = 1'b0;
    cyc(2);
    expect_out(3'd4, 1, 1, 0);
    chk("pending_last_wins");
    frame();
    frame();
    expect_out(3'd4, 1, 1, 0);
    chk("pending_fresh_count");
    expire(3'd4, "pending_expire");
    pulse_level(2'd1);
    cyc(1);
    frame();
    frame();
    bus.vsync_in  = 1'b1;
    bus.level_in  = 2'd0;
    bus.req_level = 1'b1;
    cyc(1);
    bus.req_level = 1'b0;
    expect_out(3'd1, 1, 1, 0);
    cyc(1);
    chk("restart_wins");
    expect_out(3'd1, 1, 1, 0);
    cyc(1);
    chk("restart_no_done");
    bus.vsync_in = 1'b0;
    cyc(2);
    pulse_level(2'd3);
    bus.vsync_in = 1'b1;
    cyc(100);
    bus.vsync_in = 1'b0;
    cyc(2);
    expect_out(3'd4, 1, 1, 0);
    chk("vsync_hold");
    frame();
    expect_out(3'd4, 1, 1, 0);
    chk("vsync_hold_tick2");
    expire(3'd4, "vsync_hold_expire");
    pulse_level(2'd1);
    bus.req_gameover = 1'b1;
    bus.req_level    = 1'b1;
    bus.level_in     = 2'd2;
    cyc(1);
    bus.req_gameover = 1'b0;
    bus.req_level    = 1'b0;
    expect_out(3'd6, 1, 1, 0);
    cyc(1);
    chk("gameover");
    pulse_level(2'd0);
    bus.req_pause = 1'b1;
    cyc(3);
    bus.req_pause = 1'b0;
    frame();
    frame();
    frame();
    expect_out(3'd6, 1, 1, 0);
    chk("over_sticky");
    rst = 1'b1;
    bus.req_level = 1'b1;
    cyc(1);
    rst = 1'b0;
    bus.req_level = 1'b0;
    expect_out(3'd0, 0, 0, 0);
    chk("reset_after_over");
    expect_out(3'd0, 0, 0, 0);
    cyc(2);
    chk("reset_overrides_req");
    bus.req_pause = 1'b1;
    cyc(2);
    expect_out(3'd5, 1, 1, 0);
    chk("pause_from_idle");
    bus.req_pause = 1'b0;
    cyc(2);
    expect_out(3'd0, 0, 0, 0);
    chk("pause_release_idle");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/text_scheduler.md
# text_scheduler

Sequences the in-game text overlay. Accepts level-start, pause and game-over events from game logic, arbitrates them by priority, and drives the message index and enable consumed by the text overlay path (char ROM message select and overlay gating). Display durations and pause blinking are timed in video frames derived from `vsync_in`. Sits between game control logic and the textbox overlay, in the `pclk` domain.

## Interface
Parameters:
- `SHOW_FRAMES`, 120: frames a level-start message stays visible (1..4095).
- `BLINK_FRAMES`, 16: half-period of the pause blink, in frames (1..255).

Ports:
- `pclk`  in  1  pixel clock; only clock.
- `rst`  in  1  synchronous, active-high reset.
- `vsync_in`  in  1  timing-generator vsync; each rising edge is one frame tick.
- `req_level`  in  1  one-cycle pulse: show level-start message.
- `level_in`  in  2  level number sampled with `req_level`.
- `req_pause`  in  1  level signal: pause active while high.
- `req_gameover`  in  1  one-cycle pulse: show game-over message (sticky).
- `text_en`  out  1  overlay enable for the textbox path.
- `msg_id`  out  3  message index: 0 none, 1–4 level 1–4, 5 PAUSED, 6 GAME OVER.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a timed level message expires.

## Operation
- Frame tick: `vsync_in` registered once. `tick = vsync_in & ~vsync_q`. One tick per rising edge. `vsync_in` held high does not retrigger.
- States:
  - IDLE: `msg_id`=0, `text_en`=0.
  - SHOW: `msg_id`=`level_in`+1 as captured, `text_en`=1. `frame_cnt` counts ticks.
  - PAUSE: `msg_id`=5. `text_en` per blink rule.
  - OVER: `msg_id`=6, `text_en`=1.
- Priority per cycle: `req_gameover` > `req_pause` > `req_level`.
- Transitions:
  - Any state, `req_gameover` → OVER. OVER is left only by `rst`.
  - IDLE/SHOW with `req_pause`=1 → PAUSE. A SHOW interrupted this way is suspended: `frame_cnt` and message are frozen.
  - IDLE, `req_level` → SHOW. Capture `level_in`, clear `frame_cnt`.
  - SHOW, `req_level` → restart SHOW with the new level and `frame_cnt`=0.
  - SHOW, tick with `frame_cnt`==`SHOW_FRAMES`-1 → IDLE. `done` pulses in that same cycle's registered output.
  - PAUSE, `req_level` → latch into a single pending slot. Last request wins.
  - PAUSE, `req_pause`=0:
    - pending set → SHOW with the pending level, `frame_cnt`=0, pending cleared.
    - else a suspended SHOW exists → resume SHOW with the frozen count.
    - else → IDLE.
- Simultaneous `req_level` and expiry tick in SHOW: the restart wins and no `done` pulse is issued.
- In OVER, `req_level` and `req_pause` are ignored.
- `frame_cnt` is 12 bits. `blink_cnt` is 8 bits and wraps to 0 at `BLINK_FRAMES`-1.

## Timing
- All outputs are registered. A request sampled at edge t is reflected on `msg_id`/`text_en`/`busy` after edge t+1.
- Frame-tick latency: the vsync rising edge is seen at `vsync_in` at edge t. The tick acts at edge t+1 and the outputs change after edge t+2.
- `done` is high for exactly one `pclk` cycle, coincident with `msg_id` returning to 0.
- Reset values:
  - `text_en`=0, `msg_id`=0, `busy`=0, `done`=0.
  - State is IDLE. All counters, the pending slot, the suspend flag and `vsync_q` are 0.
- Reset mid-message overrides every request in the same cycle.
- Outputs change only on `pclk` edges. Downstream samples them once per frame or per pixel, with no extra synchronisation.

## Configuration
- `TEXT_SCHED_BLINK_EN` defined:
  - In PAUSE, `text_en` toggles every `BLINK_FRAMES` ticks, starting at 1 on PAUSE entry.
  - `blink_cnt` is reset on each PAUSE entry.
- Not defined:
  - `text_en`=1 steadily in PAUSE.
  - `blink_cnt` logic is absent.

## Test plan
- Reset, then `req_level` with `level_in`=2 and `SHOW_FRAMES`=3. Expected: `msg_id`=3 and `text_en`=1 one cycle later. After the 3rd vsync rising edge, `done` pulses once and `msg_id`=0.
- In SHOW after 1 tick, raise `req_pause` for 5 frames, then drop it. Expected: `msg_id`=5 while paused, then `msg_id`=3 resumes, and `done` follows after 2 more ticks (total 3 counted).
- During PAUSE, pulse `req_level` with `level_in`=0 and then `level_in`=3, then release pause. Expected: `msg_id`=4 with a fresh count.
- `req_gameover` and `req_level` in the same cycle from SHOW. Expected: `msg_id`=6. Later `req_level`/`req_pause` have no effect until `rst`, and then all outputs return to 0.
- With `TEXT_SCHED_BLINK_EN` and `BLINK_FRAMES`=2, hold pause for 8 frames. Expected: `text_en` pattern 1,1,0,0,1,1,0,0 per frame. Without the macro, `text_en` stays 1.
- Hold `vsync_in` high for 100 cycles during SHOW. Expected: exactly one tick counted.
